dmem_responder: RTL

Data-memory responder for the pipelined core's Memory stage. It accepts the load/store request the datapath presents in M (address ALUOutM, store data WriteDataM) and holds the pipeline with MemStall for a fixed access latency. It then completes the access, performing byte-enabled writes or returning a full aligned word on ReadDataM. Load byte selection and shifting stay in the datapath's writeback selector; this block always returns the whole word.

---
 rtl/dmem_responder_if.sv | 34 +++
 rtl/dmem_responder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - M-stage data-memory request/response bundle
interface dmem_responder_if;
  logic        MemReadM;
  logic        MemWriteM;
  logic        WriteByteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemStall;
  logic        MemDone;

  // The datapath presents the request; the responder returns data and stall.
  modport master (
    output MemReadM,
    output MemWriteM,
    output WriteByteM,
    output ALUOutM,
    output WriteDataM,
    input  ReadDataM,
    input  MemStall,
    input  MemDone
  );

  modport slave (
    input  MemReadM,
    input  MemWriteM,
    input  WriteByteM,
    input  ALUOutM,
    input  WriteDataM,
    output ReadDataM,
    output MemStall,
    output MemDone
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data RAM responder for the Memory stage
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_BITS   = 10,
  parameter int LATENCY     = 3
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..15");
  end
  if ((1 << ADDR_BITS) != DEPTH_WORDS) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS must equal 2**ADDR_BITS");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_t                 state_q, state_d;
  logic [3:0]             counter_q, counter_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic                   write_q, write_d;
  logic [3:0]             be_q, be_d;
  logic [31:0]            read_data_q;
  logic                   stall;
  logic                   req;
  logic                   access_fire;

  logic [31:0]            mem [DEPTH_WORDS];

  // Upper address bits alias by design; only the word index is decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.ALUOutM[31:ADDR_BITS+2]};

  assign req         = bus.MemReadM | bus.MemWriteM;
  assign access_fire = (state_q == WAIT) && (counter_q == 4'd1);

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    addr_d    = addr_q;
    data_d    = data_q;
    write_d   = write_q;
    be_d      = be_q;
    stall     = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = req;
        if (req) begin
          state_d   = WAIT;
          counter_d = LAT4;
          addr_d    = bus.ALUOutM[ADDR_BITS+1:2];
          data_d    = bus.WriteDataM;
          // Read+write together is treated as a store.
          write_d   = bus.MemWriteM;
          be_d      = bus.WriteByteM ? (4'b0001 << bus.ALUOutM[1:0]) : 4'b1111;
        end
      end
      WAIT: begin
        stall     = 1'b1;
        counter_d = counter_q - 4'd1;
        if (counter_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // M still holds the completed instruction, so nothing is captured here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= 4'd0;
      addr_q    <= '0;
      data_q    <= 32'd0;
      write_q   <= 1'b0;
      be_q      <= 4'd0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      write_q   <= write_d;
      be_q      <= be_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data_q <= 32'd0;
    end else if (access_fire && !write_q) begin
      read_data_q <= mem[addr_q];
    end
  end

  // RAM has no reset; an access pending under reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && access_fire && write_q) begin
      for (int k = 0; k < 4; k++) begin
        if (be_q[k]) begin
          mem[addr_q][8*k +: 8] <= data_q[8*k +: 8];
        end
      end
    end
  end

  assign bus.MemStall  = stall & ~reset;
  assign bus.MemDone   = (state_q == RESP);
  assign bus.ReadDataM = read_data_q;

endmodule
